// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types and geometry helpers for the instruction cache
package icache_pkg;

  localparam int LINE_W = 128;
  localparam int BEATS  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_REFILL  = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  function automatic int idx_width(input int n_lines);
    return $clog2(n_lines);
  endfunction

  function automatic int tag_width(input int addr_w, input int n_lines);
    return addr_w - 4 - $clog2(n_lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage, one synchronous read port, one write port
module icache_array
  import icache_pkg::*;
#(
  parameter int N_LINES = 64,
  parameter int IDX_W   = 6,
  parameter int TAG_W   = 22
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [N_LINES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem  [N_LINES];
  logic [LINE_W-1:0]  data_mem [N_LINES];

  // Only the valid bits are reset; tag/data stay RAM-like and are masked by valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) valid[wr_idx] <= 1'b1;
      if (rd_en) rd_valid <= valid[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= tag_mem[rd_idx];
      rd_data <= data_mem[rd_idx];
    end
  end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with 4-beat refill
module icache
  import icache_pkg::*;
#(
  parameter int N_LINES = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] icache_pcin,
  input  logic              icache_ren,
  input  logic              icache_abort,
  output logic [LINE_W-1:0] icache_dout,
  output logic              icache_dout_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);

  localparam int IDX_W = idx_width(N_LINES);
  localparam int TAG_W = tag_width(ADDR_W, N_LINES);

  state_t              state, state_nxt;
  logic [ADDR_W-5:0]   req_line;
  logic [1:0]          beat;
  logic                aborted;
  logic [LINE_W-1:0]   line_buf;
  logic [LINE_W-1:0]   dout_q;

  logic                arr_valid;
  logic [TAG_W-1:0]    arr_tag;
  logic [LINE_W-1:0]   arr_data;
  logic                hit;
  logic                last_beat;
  logic                capture;
  logic                start_refill;
  logic                unused_offset;

  assign unused_offset = ^icache_pcin[3:0];
  assign hit       = arr_valid && (arr_tag == req_line[ADDR_W-5 -: TAG_W]);
  assign last_beat = (state == S_REFILL) && mem_rdata_valid && (beat == 2'd3);

  icache_array #(
    .N_LINES(N_LINES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_en   (capture),
    .rd_idx  (icache_pcin[4 +: IDX_W]),
    .rd_valid(arr_valid),
    .rd_tag  (arr_tag),
    .rd_data (arr_data),
    .wr_en   (last_beat),
    .wr_idx  (req_line[IDX_W-1:0]),
    .wr_tag  (req_line[ADDR_W-5 -: TAG_W]),
    .wr_data ({mem_rdata, line_buf[LINE_W-WORD_W-1:0]})
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (icache_ren) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (hit || icache_abort) state_nxt = icache_ren ? S_LOOKUP : S_IDLE;
        else                     state_nxt = S_REFILL;
      end
      // The refill always runs to the end; an abort only drops the response.
      S_REFILL:  if (last_beat) state_nxt = (aborted || icache_abort) ? S_IDLE : S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capture           = 1'b0;
    start_refill      = 1'b0;
    icache_dout_valid = 1'b0;
    icache_dout       = dout_q;
    case (state)
      S_IDLE: capture = icache_ren;
      S_LOOKUP: begin
        if (hit || icache_abort) begin
          capture = icache_ren;
          if (!icache_abort) begin
            icache_dout_valid = 1'b1;
            icache_dout       = arr_data;
          end
        end else begin
          start_refill = 1'b1;
        end
      end
      S_RESPOND: begin
        if (!icache_abort) begin
          icache_dout_valid = 1'b1;
          icache_dout       = line_buf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_line <= '0;
      beat     <= 2'd0;
      aborted  <= 1'b0;
      line_buf <= '0;
      dout_q   <= '0;
      mem_addr <= '0;
      mem_ren  <= 1'b0;
    end else begin
      if (capture)           req_line <= icache_pcin[ADDR_W-1:4];
      if (icache_dout_valid) dout_q   <= icache_dout;
      if (start_refill) begin
        beat     <= 2'd0;
        aborted  <= 1'b0;
        mem_addr <= {req_line, 4'h0};
        mem_ren  <= 1'b1;
      end
      if (state == S_REFILL) begin
        if (icache_abort) aborted <= 1'b1;
        if (mem_rdata_valid) begin
          line_buf[{beat, 5'b0} +: WORD_W] <= mem_rdata;
          beat     <= beat + 2'd1;
          mem_addr <= mem_addr + ADDR_W'(4);
          if (beat == 2'd3) mem_ren <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - table-driven, directed and randomized checks for icache
module tb_icache;

  localparam int N_LINES = 64;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  icache_pcin;
  logic         icache_ren;
  logic         icache_abort;
  logic [127:0] icache_dout;
  logic         icache_dout_valid;
  logic [31:0]  mem_addr;
  logic         mem_ren;
  logic [31:0]  mem_rdata;
  logic         mem_rdata_valid;

  always #5 clk = ~clk;

  icache #(.N_LINES(N_LINES), .ADDR_W(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .icache_pcin      (icache_pcin),
    .icache_ren       (icache_ren),
    .icache_abort     (icache_abort),
    .icache_dout      (icache_dout),
    .icache_dout_valid(icache_dout_valid),
    .mem_addr         (mem_addr),
    .mem_ren          (mem_ren),
    .mem_rdata        (mem_rdata),
    .mem_rdata_valid  (mem_rdata_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mem_gate_random = 1'b0;

  logic [31:0]  seen_beats [$];
  logic [127:0] resp_q [$];
  int           resp_cyc [$];
  logic [31:0]  backing [logic [31:0]];

  bit          mvalid [N_LINES];
  logic [21:0] mtag   [N_LINES];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'h0};
    return {mem_word(b + 32'd12), mem_word(b + 32'd8), mem_word(b + 32'd4), mem_word(b)};
  endfunction

  always @(negedge clk) begin : mem_model
    bit v;
    v = mem_ren && (!mem_gate_random || ($urandom_range(0, 9) < 6));
    mem_rdata       <= mem_word(mem_addr);
    mem_rdata_valid <= v;
    if (v) seen_beats.push_back(mem_addr);
  end

  always @(negedge clk) begin
    #2;
    if (icache_dout_valid === 1'b1) begin
      resp_q.push_back(icache_dout);
      resp_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic [31:0] a, input logic ab);
    @(negedge clk);
    icache_ren   = ren;
    icache_pcin  = a;
    icache_abort = ab;
  endtask

  task automatic begin_seq();
    drive(1'b0, 32'h0, 1'b0);
    #3;
    seen_beats.delete();
    resp_q.delete();
    resp_cyc.delete();
  endtask

  task automatic end_seq(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0);
    #3;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_dout"}, icache_dout, 128'h0);
    chk({tag, "_dout_valid"}, icache_dout_valid, 1'b0);
    chk({tag, "_mem_ren"}, mem_ren, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
  endtask

  task automatic run_txn(input logic [31:0] a, input int mode, input int ab_at,
                         output int nresp, output int nbeats, output bit beats_ok,
                         output int lat, output logic [127:0] line);
    int req_cyc;
    int n;
    int zeros;
    bit ab_done;
    bit done;
    logic [31:0] base;
    begin_seq();
    drive(1'b1, a, 1'b0);
    req_cyc = cyc;
    n = 0; zeros = 0; ab_done = 0; done = 0;
    while (n < 400) begin
      drive(1'b0, a, (mode == 1 && n == 0));
      #1;
      if (mode == 2 && !ab_done && mem_ren && seen_beats.size() >= ab_at) begin
        icache_abort = 1'b1;
        ab_done = 1'b1;
      end
      n++;
      zeros = mem_ren ? 0 : zeros + 1;
      if (n >= 3 && zeros >= 2) begin
        done = 1'b1;
        break;
      end
    end
    #3;
    chk("txn_done", done, 1'b1);
    nresp  = resp_q.size();
    nbeats = seen_beats.size();
    line   = (nresp > 0) ? resp_q[0] : 128'h0;
    lat    = (nresp > 0) ? resp_cyc[0] - req_cyc : -1;
    base   = {a[31:4], 4'h0};
    beats_ok = (nbeats == 4);
    for (int i = 0; i < nbeats; i++)
      if (seen_beats[i] !== base + 32'(4 * i)) beats_ok = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          mode;
    int          exp_resp;
    int          exp_beats;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t         vecs [7];
    int           nresp, nbeats, lat, rc0;
    bit           bok;
    logic [127:0] line;
    logic [31:0]  a;
    int           mode, r, idx;
    bit           hit;
    int           n;

    backing[32'h100] = 32'h11;
    backing[32'h104] = 32'h22;
    backing[32'h108] = 32'h33;
    backing[32'h10C] = 32'h44;

    vecs[0] = '{32'h0000_0100, 0, 1, 4, 6};  // cold miss
    vecs[1] = '{32'h0000_0110, 0, 1, 4, 6};
    vecs[2] = '{32'h0000_0104, 0, 1, 0, 1};  // offset bits ignored, hit
    vecs[3] = '{32'h0000_0500, 0, 1, 4, 6};  // same index as 0x100
    vecs[4] = '{32'h0000_0100, 0, 1, 4, 6};  // evicted by the conflict
    vecs[5] = '{32'h0000_0600, 1, 0, 0, -1}; // abort in lookup: no refill
    vecs[6] = '{32'h0000_0600, 0, 1, 4, 6};

    icache_ren = 1'b0; icache_pcin = 32'h0; icache_abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].addr, vecs[i].mode, 0, nresp, nbeats, bok, lat, line);
      chk($sformatf("vec%0d_resp", i), nresp, vecs[i].exp_resp);
      chk($sformatf("vec%0d_beats", i), nbeats, vecs[i].exp_beats);
      if (vecs[i].exp_beats > 0) chk($sformatf("vec%0d_beat_addr", i), bok, 1'b1);
      if (vecs[i].exp_resp > 0) begin
        chk($sformatf("vec%0d_line", i), line, line_of(vecs[i].addr));
        chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      end
      if (i == 0) chk("cold_line_literal", line, 128'h00000044_00000033_00000022_00000011);
    end

    // back-to-back hits
    begin_seq();
    drive(1'b1, 32'h100, 1'b0);
    rc0 = cyc;
    drive(1'b1, 32'h110, 1'b0);
    drive(1'b1, 32'h100, 1'b0);
    end_seq(4);
    chk("b2b_count", resp_q.size(), 3);
    chk("b2b_beats", seen_beats.size(), 0);
    if (resp_q.size() == 3) begin
      chk("b2b_line0", resp_q[0], line_of(32'h100));
      chk("b2b_line1", resp_q[1], line_of(32'h110));
      chk("b2b_line2", resp_q[2], line_of(32'h100));
      chk("b2b_cyc0", resp_cyc[0] - rc0, 1);
      chk("b2b_cyc1", resp_cyc[1] - rc0, 2);
      chk("b2b_cyc2", resp_cyc[2] - rc0, 3);
    end

    // abort after beat 1 of a refill
    run_txn(32'h200, 2, 2, nresp, nbeats, bok, lat, line);
    chk("abrt_refill_resp", nresp, 0);
    chk("abrt_refill_beats", nbeats, 4);
    chk("abrt_refill_addr", bok, 1'b1);
    run_txn(32'h200, 0, 0, nresp, nbeats, bok, lat, line);
    chk("abrt_then_hit_resp", nresp, 1);
    chk("abrt_then_hit_beats", nbeats, 0);
    chk("abrt_then_hit_lat", lat, 1);
    chk("abrt_then_hit_line", line, line_of(32'h200));

    // abort plus new request in lookup
    begin_seq();
    drive(1'b1, 32'h100, 1'b0);
    rc0 = cyc;
    drive(1'b1, 32'h110, 1'b1);
    end_seq(4);
    chk("abrt_lookup_count", resp_q.size(), 1);
    if (resp_q.size() == 1) begin
      chk("abrt_lookup_line", resp_q[0], line_of(32'h110));
      chk("abrt_lookup_cyc", resp_cyc[0] - rc0, 2);
    end

    // reset in the middle of a refill
    begin_seq();
    drive(1'b1, 32'h300, 1'b0);
    n = 0;
    while (n < 20) begin
      drive(1'b0, 32'h0, 1'b0);
      #1;
      n++;
      if (seen_beats.size() >= 3) break;
    end
    chk("rst_mid_reached", seen_beats.size() >= 3, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    run_txn(32'h300, 0, 0, nresp, nbeats, bok, lat, line);
    chk("rst_mid_miss_beats", nbeats, 4);
    chk("rst_mid_miss_lat", lat, 6);
    chk("rst_mid_miss_line", line, line_of(32'h300));
    run_txn(32'h100, 0, 0, nresp, nbeats, bok, lat, line);
    chk("rst_valid_cleared", nbeats, 4);

    // randomized phase against a line-level cache model
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    mem_gate_random = 1'b1;
    for (int t = 0; t < 150; t++) begin
      a = {20'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      r = $urandom_range(0, 99);
      mode = (r < 70) ? 0 : (r < 85) ? 1 : 2;
      idx = int'(a[9:4]);
      hit = mvalid[idx] && (mtag[idx] == a[31:10]);
      run_txn(a, mode, $urandom_range(0, 3), nresp, nbeats, bok, lat, line);
      chk($sformatf("rnd%0d_resp", t), nresp, (mode == 0 || (mode == 2 && hit)) ? 1 : 0);
      chk($sformatf("rnd%0d_beats", t), nbeats, (!hit && mode != 1) ? 4 : 0);
      if (!hit && mode != 1) begin
        chk($sformatf("rnd%0d_beat_addr", t), bok, 1'b1);
        mvalid[idx] = 1'b1;
        mtag[idx]   = a[31:10];
      end
      if (nresp > 0) begin
        chk($sformatf("rnd%0d_line", t), line, line_of(a));
        if (hit) chk($sformatf("rnd%0d_hit_lat", t), lat, 1);
        else     chk($sformatf("rnd%0d_miss_lat", t), lat >= 6, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache: the responder end of the instruction-fetch request interface. Accepts line-aligned fetch requests from the instruction fetch queue and returns 128-bit lines (4 instructions) with a valid strobe. Misses are refilled from a 32-bit backing-memory port in four sequential beats.

## Interface
- N_LINES, 64: number of cache lines (power of two). Index = pcin[4+IDX_W-1:4]; tag = pcin[31:4+IDX_W].
- ADDR_W, 32: fetch address width.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- icache_pcin  in  32  fetch address; bits [3:0] ignored (line aligned).
- icache_ren  in  1  fetch request; sampled at the rising edge.
- icache_abort  in  1  cancel the outstanding request (branch redirect).
- icache_dout  out  128  fetched line; word0 = bits [31:0] = lowest address.
- icache_dout_valid  out  1  icache_dout holds the line of the oldest unaborted request.
- mem_addr  out  32  backing-memory word address (byte address, 4-aligned).
- mem_ren  out  1  beat request, held until mem_rdata_valid.
- mem_rdata  in  32  backing-memory read data.
- mem_rdata_valid  in  1  one beat returned this cycle.

## Operation
- States: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE: icache_ren=1 captures pcin into req_addr, starts synchronous array read at index -> LOOKUP. Otherwise stay.
- LOOKUP: compare stored tag with req_addr tag and valid bit.
  - Hit, no abort: icache_dout_valid=1, icache_dout=array line. If icache_ren=1 the new request is captured (back-to-back hits, stay LOOKUP), else -> IDLE.
  - Hit or miss with abort=1: no valid strobe; if icache_ren=1 same cycle, new request captured -> LOOKUP, else -> IDLE.
  - Miss, no abort: beat counter=0, mem_addr={req_addr[31:4],4'h0}, mem_ren=1 -> REFILL.
- REFILL: on each mem_rdata_valid store beat into line buffer word[beat], beat+1, mem_addr+4. After beat 3: write line, tag, valid=1 to array at index. If aborted flag set -> IDLE (no response), else -> RESPOND. mem_ren deasserted the cycle after beat 3 returns.
- icache_abort during REFILL sets aborted flag; refill always completes (memory port is never abandoned mid-line).
- RESPOND: icache_dout_valid=1, icache_dout=line buffer, one cycle -> IDLE. Abort here suppresses the strobe.
- icache_ren in REFILL or RESPOND is ignored (not accepted); requester re-issues.
- Beat counter 2 bits, wraps 3->0; mem_addr increments only on mem_rdata_valid.
- Valid bits cleared only by reset; no invalidate, no write path.

## Timing
- Reset (async assert, sync deassert usage): state=IDLE, all valid bits 0, icache_dout=0, icache_dout_valid=0, mem_ren=0, mem_addr=0, beat=0, aborted=0. Reset mid-refill discards the line; array data RAM contents undefined but unreachable.
- Hit latency: request at edge N -> icache_dout_valid high during cycle N+1. Sustained throughput one line per cycle on hits.
- Miss latency: 1 (lookup) + memory beats + 1 (RESPOND). Zero-wait memory (valid same cycle as ren) -> dout_valid 6 cycles after request.
- icache_dout_valid is registered-state driven, a single-cycle pulse per delivered line; icache_dout holds last value otherwise.
- Abort takes effect combinationally on the strobe in the same cycle.

## Structure
- icache_pkg: state encoding, IDX_W=$clog2(N_LINES), TAG_W=ADDR_W-4-IDX_W, LINE_W=128, BEATS=4.
- Sub-module icache_array: valid/tag/data storage, one synchronous read port, one write port, async valid clear on reset_n. Top holds FSM, request register, line buffer, beat counter.

## Test plan
- Cold miss: reset, ren @0x0000_0100, memory returns 0x11,0x22,0x33,0x44 zero-wait -> mem_addr 0x100..0x10C, dout_valid once, dout=0x00000044_00000033_00000022_00000011.
- Hit back-to-back: after fill of 0x100 and 0x110, ren on consecutive cycles 0x100,0x110,0x100 -> three consecutive dout_valid pulses, correct lines, mem_ren stays 0.
- Conflict: fill 0x100, then request 0x100+N_LINES*16 (same index) -> miss, refill, then 0x100 misses again.
- Abort in REFILL: miss @0x200, abort after beat 1 -> refill completes, no dout_valid; later ren @0x200 hits in 1 cycle.
- Abort+ren in LOOKUP: hit request @0x100 with abort and new ren @0x110 same cycle -> no strobe for 0x100, line 0x110 delivered next cycle.
- Reset mid-refill: reset_n low after beat 2 -> outputs 0 immediately; subsequent ren to that line misses.
